// File: rtl/jtopl_eg_ctrl_pkg.sv
// jtopl_eg_ctrl_pkg: shared envelope encodings and widths.
// Contents: EG state enum, the silent attenuation value and the global timer width.
package jtopl_eg_ctrl_pkg;
  typedef enum logic [1:0] {ATTACK = 2'd0, DECAY = 2'd1, SUSTAIN = 2'd2, RELEASE = 2'd3} eg_state_t;
  localparam logic [8:0] EG_MAX = 9'h1FF;
  localparam int EG_CNT_W = 15;
endpackage

// File: rtl/jtopl_eg_ctrl_if.sv
// jtopl_eg_ctrl_if: link between the envelope controller and the envelope step block.
// master (controller): drives attack/base_rate/eg_cnt/cnt_in; receives step/rate/cnt_lsb/sum_up.
// slave (step block): the mirror image.
interface jtopl_eg_ctrl_if;
  import jtopl_eg_ctrl_pkg::*;
  logic                attack;
  logic [4:0]          base_rate;
  logic [EG_CNT_W-1:0] eg_cnt;
  logic                cnt_in;
  logic                step;
  logic [5:0]          rate;
  logic                cnt_lsb;
  logic                sum_up;
  modport master (output attack, base_rate, eg_cnt, cnt_in, input step, rate, cnt_lsb, sum_up);
  modport slave (input attack, base_rate, eg_cnt, cnt_in, output step, rate, cnt_lsb, sum_up);
endinterface

// File: rtl/jtopl_eg_upd.sv
// jtopl_eg_upd: combinational next state/level for one slot.
// Inputs: stored state/level/keyon_last, current keyon, ar, sl, step-block step/sum_up/rate.
// Outputs: st_nx, lvl_nx to be written back for the slot.
module jtopl_eg_upd
  import jtopl_eg_ctrl_pkg::*;
(
  input  eg_state_t  st,
  input  logic [8:0] lvl,
  input  logic       keyon,
  input  logic       kon_last,
  input  logic       step,
  input  logic       sum_up,
  input  logic [5:0] rate,
  input  logic [3:0] ar,
  input  logic [3:0] sl,
  output eg_state_t  st_nx,
  output logic [8:0] lvl_nx
);
  logic [8:0] inc, dn, up;
  logic [9:0] sum;
  logic [4:0] thr;
  always_comb begin
    // rate[5:2] of 13/14/15 corresponds to rate >= 52/56/60
    inc = rate >= 6'd60 ? 9'd8 : rate >= 6'd56 ? 9'd4 : rate >= 6'd52 ? 9'd2 : 9'd1;
    sum = {1'b0, lvl} + {1'b0, inc};
    up = sum[9] ? EG_MAX : sum[8:0];
    dn = lvl - (lvl >> 3) - 9'd1;
    thr = sl == 4'hF ? 5'h1F : {1'b0, sl};
    st_nx = st;
    lvl_nx = lvl;
    if (keyon && !kon_last) begin
      st_nx = ar == 4'hF ? DECAY : ATTACK;
      lvl_nx = ar == 4'hF ? 9'd0 : lvl;
    end else begin
      if (!keyon) st_nx = RELEASE;
      if (step && sum_up) begin
        if (st == ATTACK && keyon) begin
          st_nx = lvl == 9'd0 ? DECAY : ATTACK;
          lvl_nx = lvl == 9'd0 ? 9'd0 : dn;
        end else begin
          lvl_nx = up;
          if (st == DECAY && keyon && up[8:4] >= thr) st_nx = SUSTAIN;
        end
      end
    end
  end
endmodule

// File: rtl/jtopl_eg_ctrl.sv
// jtopl_eg_ctrl: time-multiplexed envelope state machine over SLOTS operator slots.
// Ports: clk/rst/cen; slot out for parent muxing; per-slot keyon/ar/dr/rr/sl/en_sus in;
// eg_if (master) to the step block; eg_out/eg_slot/eg_valid report the written-back level.
module jtopl_eg_ctrl
  import jtopl_eg_ctrl_pkg::*;
#(
  parameter int SLOTS = 18,
  parameter int SW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  output logic [SW-1:0] slot,
  input  logic          keyon,
  input  logic [3:0]    ar,
  input  logic [3:0]    dr,
  input  logic [3:0]    rr,
  input  logic [3:0]    sl,
  input  logic          en_sus,
  jtopl_eg_ctrl_if.master eg_if,
  output logic [8:0]    eg_out,
  output logic [SW-1:0] eg_slot,
  output logic          eg_valid
);
  eg_state_t           st_q [SLOTS];
  logic [8:0]          lvl_q [SLOTS];
  logic [SLOTS-1:0]    kl_q, cl_q;
  logic [SW-1:0]       slot_q, slot_d, eg_slot_q, eg_slot_d;
  logic [EG_CNT_W-1:0] eg_cnt_q, eg_cnt_d;
  logic [8:0]          eg_out_q, eg_out_d, cur_lvl, nx_lvl;
  logic                eg_valid_q, eg_valid_d, wrap;
  logic [3:0]          r;
  eg_state_t           cur_st, nx_st;

  jtopl_eg_upd u_upd (
    .st(cur_st), .lvl(cur_lvl), .keyon(keyon), .kon_last(kl_q[slot_q]),
    .step(eg_if.step), .sum_up(eg_if.sum_up), .rate(eg_if.rate),
    .ar(ar), .sl(sl), .st_nx(nx_st), .lvl_nx(nx_lvl)
  );

  always_comb begin
    cur_st = st_q[slot_q];
    cur_lvl = lvl_q[slot_q];
    r = cur_st == ATTACK ? ar : cur_st == DECAY ? dr : (cur_st == SUSTAIN && en_sus) ? 4'd0 : rr;
    eg_if.base_rate = {r, 1'b0};
    eg_if.attack = cur_st == ATTACK;
    eg_if.eg_cnt = eg_cnt_q;
    eg_if.cnt_in = cl_q[slot_q];
    wrap = slot_q == SW'(SLOTS - 1);
    slot_d = cen ? (wrap ? '0 : slot_q + 1'b1) : slot_q;
    eg_cnt_d = (cen && wrap) ? eg_cnt_q + 1'b1 : eg_cnt_q;
    eg_out_d = cen ? nx_lvl : eg_out_q;
    eg_slot_d = cen ? slot_q : eg_slot_q;
    eg_valid_d = cen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      eg_cnt_q <= '0;
      eg_out_q <= EG_MAX;
      eg_slot_q <= '0;
      eg_valid_q <= 1'b0;
      kl_q <= '0;
      cl_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        st_q[i] <= RELEASE;
        lvl_q[i] <= EG_MAX;
      end
    end else begin
      slot_q <= slot_d;
      eg_cnt_q <= eg_cnt_d;
      eg_out_q <= eg_out_d;
      eg_slot_q <= eg_slot_d;
      eg_valid_q <= eg_valid_d;
      if (cen) begin
        st_q[slot_q] <= nx_st;
        lvl_q[slot_q] <= nx_lvl;
        kl_q[slot_q] <= keyon;
        cl_q[slot_q] <= eg_if.cnt_lsb;
      end
    end
  end

  assign slot = slot_q;
  assign eg_out = eg_out_q;
  assign eg_slot = eg_slot_q;
  assign eg_valid = eg_valid_q;
endmodule

// File: tb/tb_jtopl_eg_ctrl.sv
// tb_jtopl_eg_ctrl: directed bench for jtopl_eg_ctrl; the bench plays the step block for slot 0.
module tb_jtopl_eg_ctrl;
  logic        clk = 0, rst = 1, cen = 1, keyon = 0, en_sus = 1;
  logic [3:0]  ar = 4'd5, dr = 4'd6, rr = 4'd7, sl = 4'd4;
  logic [4:0]  slot, eg_slot;
  logic [8:0]  eg_out;
  logic        eg_valid;
  int          vec = 0, fails = 0;
  int          exp_slot = 0;
  logic [14:0] exp_cnt = 0;
  logic        prev_cl = 0;
  logic [8:0]  l;

  jtopl_eg_ctrl_if eg_if ();

  jtopl_eg_ctrl #(.SLOTS(18), .SW(5)) dut (
    .clk(clk), .rst(rst), .cen(cen), .slot(slot), .keyon(keyon),
    .ar(ar), .dr(dr), .rr(rr), .sl(sl), .en_sus(en_sus), .eg_if(eg_if),
    .eg_out(eg_out), .eg_slot(eg_slot), .eg_valid(eg_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic advance();
    if (exp_slot == 17) begin
      exp_slot = 0;
      exp_cnt = exp_cnt + 1'b1;
    end else exp_slot++;
  endtask

  task automatic idle();
    keyon = 0;
    eg_if.step = 0;
    eg_if.sum_up = 0;
    eg_if.rate = 0;
    eg_if.cnt_lsb = 0;
    @(posedge clk);
    #1;
    advance();
  endtask

  // one processed cycle of slot 0; cnt_lsb toggles every visit
  task automatic visit(input logic kon, input logic stp, input logic sum, input logic [5:0] rt,
                       input logic exp_att, input logic [4:0] exp_br, input logic [8:0] exp_lvl);
    logic cl;
    while (exp_slot != 0) idle();
    cl = ~prev_cl;
    keyon = kon;
    eg_if.step = stp;
    eg_if.sum_up = sum;
    eg_if.rate = rt;
    eg_if.cnt_lsb = cl;
    #1;
    chk("slot", 16'(slot), 16'd0);
    chk("attack", 16'(eg_if.attack), 16'(exp_att));
    chk("base_rate", 16'(eg_if.base_rate), 16'(exp_br));
    chk("cnt_in", 16'(eg_if.cnt_in), 16'(prev_cl));
    chk("eg_cnt", 16'(eg_if.eg_cnt), 16'(exp_cnt));
    @(posedge clk);
    #1;
    advance();
    chk("eg_out", 16'(eg_out), 16'(exp_lvl));
    chk("eg_slot", 16'(eg_slot), 16'd0);
    chk("eg_valid", 16'(eg_valid), 16'd1);
    prev_cl = cl;
  endtask

  initial begin
    eg_if.step = 0;
    eg_if.sum_up = 0;
    eg_if.rate = 0;
    eg_if.cnt_lsb = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_slot", 16'(slot), 16'd0);
    chk("rst_eg_cnt", 16'(eg_if.eg_cnt), 16'd0);
    chk("rst_eg_out", 16'(eg_out), 16'h1FF);
    chk("rst_eg_valid", 16'(eg_valid), 16'd0);
    chk("rst_eg_slot", 16'(eg_slot), 16'd0);
    rst = 0;
    for (int i = 0; i < 18; i++) begin
      idle();
      chk("sweep_eg_out", 16'(eg_out), 16'h1FF);
      chk("sweep_eg_slot", 16'(eg_slot), 16'(i));
      chk("sweep_eg_valid", 16'(eg_valid), 16'd1);
    end
    chk("sweep_eg_cnt", 16'(eg_if.eg_cnt), 16'd1);
    cen = 0;
    @(posedge clk);
    #1;
    chk("cen0_valid", 16'(eg_valid), 16'd0);
    chk("cen0_slot", 16'(slot), 16'(exp_slot));
    chk("cen0_eg_cnt", 16'(eg_if.eg_cnt), 16'(exp_cnt));
    cen = 1;
    // key-on edge together with a step: no level change, enter ATTACK
    visit(1, 1, 1, 6'h14, 0, 5'd14, 9'h1FF);
    visit(1, 1, 1, 6'h14, 1, 5'd10, 9'h1BF);
    visit(1, 1, 1, 6'h14, 1, 5'd10, 9'h187);
    visit(1, 1, 1, 6'h14, 1, 5'd10, 9'h156);
    visit(1, 1, 0, 6'h14, 1, 5'd10, 9'h156);
    l = 9'h156;
    for (int n = 0; n < 200 && l != 0; n++) begin
      l = l - (l >> 3) - 9'd1;
      visit(1, 1, 1, 6'h14, 1, 5'd10, l);
    end
    chk("attack_reached_0", 16'(l), 16'd0);
    visit(1, 1, 1, 6'h14, 1, 5'd10, 9'h000);
    // DECAY with rate[5:2]=13 (+2) until level[8:4] reaches sl=4
    for (int n = 1; n <= 32; n++) visit(1, 1, 1, 6'h34, 0, 5'd12, 9'(2 * n));
    visit(1, 0, 0, 6'h00, 0, 5'd0, 9'h040);
    visit(1, 0, 0, 6'h00, 0, 5'd0, 9'h040);
    en_sus = 0;
    visit(1, 0, 0, 6'h00, 0, 5'd14, 9'h040);
    en_sus = 1;
    // key-off from SUSTAIN, then release at +8 up to saturation
    visit(0, 0, 0, 6'h00, 0, 5'd0, 9'h040);
    l = 9'h040;
    for (int n = 0; n < 60; n++) begin
      l = (l > 9'h1F7) ? 9'h1FF : l + 9'd8;
      visit(0, 1, 1, 6'h3C, 0, 5'd14, l);
    end
    visit(0, 1, 1, 6'h3C, 0, 5'd14, 9'h1FF);
    // ar=15 key-on jumps straight to level 0 in DECAY
    ar = 4'hF;
    visit(1, 0, 0, 6'h00, 0, 5'd14, 9'h000);
    visit(1, 0, 0, 6'h00, 0, 5'd12, 9'h000);
    // reset mid-sweep
    repeat (5) idle();
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_slot", 16'(slot), 16'd0);
    chk("mid_rst_eg_out", 16'(eg_out), 16'h1FF);
    chk("mid_rst_valid", 16'(eg_valid), 16'd0);
    chk("mid_rst_eg_cnt", 16'(eg_if.eg_cnt), 16'd0);
    rst = 0;
    exp_slot = 0;
    exp_cnt = 0;
    idle();
    chk("post_rst_eg_slot", 16'(eg_slot), 16'd0);
    chk("post_rst_valid", 16'(eg_valid), 16'd1);
    chk("post_rst_eg_out", 16'(eg_out), 16'h1FF);
    chk("post_rst_slot", 16'(slot), 16'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule
